// File: rtl/pong_round_ctrl.sv
// pong_round_ctrl: round lifecycle sequencer driving puck re-centre, motion enable, speed, score and lives
module pong_round_ctrl #(
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 30,
  parameter int LIVES          = 3,
  parameter int BASE_SPEED     = 2,
  parameter int MAX_SPEED      = 8,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic       nf_in,
  input  logic       start_in,
  input  logic       pause_in,
  input  logic       hit_in,
  input  logic       miss_in,
  output logic [2:0] state_out,
  output logic       serve_out,
  output logic       run_out,
  output logic [3:0] speed_out,
  output logic [7:0] score_out,
  output logic [2:0] lives_out,
  output logic       game_over_out
);
  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4;
  logic [15:0] fc, fc_n;
  logic [7:0] hc, hc_n, sc_n;
  logic [3:0] spd_n;
  logic [2:0] nxt, lv_n;
  logic start_q, start_edge;
  assign start_edge = start_in & ~start_q;
  always_comb begin
    nxt = state_out;
    fc_n = fc;
    hc_n = hc;
    spd_n = speed_out;
    sc_n = score_out;
    lv_n = lives_out;
    if ((state_out == IDLE || state_out == OVER) && start_edge) begin
      nxt = SERVE;
      lv_n = 3'(LIVES);
      sc_n = '0;
      spd_n = 4'(BASE_SPEED);
      hc_n = '0;
      fc_n = 16'(SERVE_FRAMES);
    end else if (state_out == SERVE && nf_in) begin
      fc_n = fc - 16'd1;
      nxt = fc == 16'd1 ? PLAY : SERVE;
    end else if (state_out == MISS && nf_in) begin
      fc_n = fc == 16'd1 ? 16'(SERVE_FRAMES) : fc - 16'd1;
      nxt = fc == 16'd1 ? SERVE : MISS;
    end else if (state_out == PLAY && miss_in) begin
      lv_n = lives_out - 3'd1;
      nxt = lives_out == 3'd1 ? OVER : MISS;
      fc_n = 16'(MISS_FRAMES);
    end else if (state_out == PLAY && hit_in) begin
      sc_n = score_out == 8'hff ? score_out : score_out + 8'd1;
      hc_n = hc == 8'(HITS_PER_LEVEL - 1) ? 8'd0 : hc + 8'd1;
      spd_n = (hc == 8'(HITS_PER_LEVEL - 1) && speed_out < 4'(MAX_SPEED)) ? speed_out + 4'd1 : speed_out;
    end
  end
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      start_q <= 1'b1;
      fc <= '0;
      hc <= '0;
      state_out <= IDLE;
      serve_out <= 1'b0;
      run_out <= 1'b0;
      speed_out <= 4'(BASE_SPEED);
      score_out <= '0;
      lives_out <= 3'(LIVES);
      game_over_out <= 1'b0;
    end else begin
      start_q <= start_in;
      fc <= fc_n;
      hc <= hc_n;
      state_out <= nxt;
      serve_out <= nxt == SERVE && state_out != SERVE;
      run_out <= nxt == PLAY && !pause_in;
      speed_out <= spd_n;
      score_out <= sc_n;
      lives_out <= lv_n;
      game_over_out <= nxt == OVER;
    end
  end
endmodule

// File: tb/tb_pong_round_ctrl.sv
// tb_pong_round_ctrl: directed-step bench for pong_round_ctrl with immediate assertions
module tb_pong_round_ctrl;
  logic clk = 1'b0;
  logic rst_n, nf, start, pause, hit, miss;
  logic [2:0] state, lives;
  logic serve, run, go;
  logic [3:0] speed;
  logic [7:0] score;
  int checks = 0;
  int failures = 0;

  pong_round_ctrl #(
    .SERVE_FRAMES(2), .MISS_FRAMES(1), .LIVES(2),
    .BASE_SPEED(2), .MAX_SPEED(3), .HITS_PER_LEVEL(2)
  ) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .nf_in(nf), .start_in(start),
    .pause_in(pause), .hit_in(hit), .miss_in(miss), .state_out(state),
    .serve_out(serve), .run_out(run), .speed_out(speed), .score_out(score),
    .lives_out(lives), .game_over_out(go)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 8'(state), 8'd0);
    chk({tag, "_serve"}, 8'(serve), 8'd0);
    chk({tag, "_run"}, 8'(run), 8'd0);
    chk({tag, "_speed"}, 8'(speed), 8'd2);
    chk({tag, "_score"}, score, 8'd0);
    chk({tag, "_lives"}, 8'(lives), 8'd2);
    chk({tag, "_go"}, 8'(go), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; nf = 1'b0; start = 1'b1; pause = 1'b0; hit = 1'b0; miss = 1'b0;
    tick(); tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk("held_start_idle", 8'(state), 8'd0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("start_state", 8'(state), 8'd1);
    chk("start_serve", 8'(serve), 8'd1);
    start = 1'b0; tick();
    chk("serve_one_pulse", 8'(serve), 8'd0);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("serve_after_nf1", 8'(state), 8'd1);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("play_state", 8'(state), 8'd2);
    chk("play_run", 8'(run), 8'd1);
    chk("play_lives", 8'(lives), 8'd2);
    chk("play_speed", 8'(speed), 8'd2);
    for (int i = 1; i <= 5; i++) begin
      hit = 1'b1; tick(); hit = 1'b0;
      chk("hit_score", score, 8'(i));
      chk("hit_speed", 8'(speed), i >= 2 ? 8'd3 : 8'd2);
    end
    miss = 1'b1; tick(); miss = 1'b0;
    chk("miss_state", 8'(state), 8'd3);
    chk("miss_lives", 8'(lives), 8'd1);
    chk("miss_run", 8'(run), 8'd0);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("reserve_state", 8'(state), 8'd1);
    chk("reserve_pulse", 8'(serve), 8'd1);
    tick();
    chk("reserve_pulse_end", 8'(serve), 8'd0);
    nf = 1'b1; tick(); tick(); nf = 1'b0;
    chk("replay_state", 8'(state), 8'd2);
    chk("replay_score", score, 8'd5);
    chk("replay_speed", 8'(speed), 8'd3);
    pause = 1'b1; tick();
    chk("pause_run", 8'(run), 8'd0);
    chk("pause_state", 8'(state), 8'd2);
    hit = 1'b1; tick(); hit = 1'b0;
    chk("pause_hit_score", score, 8'd6);
    tick();
    chk("pause_run_still", 8'(run), 8'd0);
    pause = 1'b0; tick();
    chk("unpause_run", 8'(run), 8'd1);
    chk("unpause_state", 8'(state), 8'd2);
    hit = 1'b1; miss = 1'b1; start = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
    chk("over_state", 8'(state), 8'd4);
    chk("over_lives", 8'(lives), 8'd0);
    chk("over_go", 8'(go), 8'd1);
    chk("over_score", score, 8'd6);
    chk("over_run", 8'(run), 8'd0);
    tick(); tick();
    chk("over_held_start", 8'(state), 8'd4);
    start = 1'b0; tick();
    start = 1'b1; nf = 1'b1; tick(); start = 1'b0; nf = 1'b0;
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_serve", 8'(serve), 8'd1);
    chk("restart_score", score, 8'd0);
    chk("restart_lives", 8'(lives), 8'd2);
    chk("restart_speed", 8'(speed), 8'd2);
    chk("restart_go", 8'(go), 8'd0);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("coincident_nf_ignored", 8'(state), 8'd1);
    nf = 1'b1; tick(); nf = 1'b0;
    chk("restart_play", 8'(state), 8'd2);
    for (int i = 0; i < 5; i++) begin
      hit = 1'b1; tick(); hit = 1'b0;
    end
    chk("pre_reset_score", score, 8'd5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_reset("midgame_reset");
    tick();
    chk("post_reset_idle", 8'(state), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pong_round_ctrl.md
# pong_round_ctrl

Game-flow sequencer for the pong datapath. Owns the round lifecycle: idle, serve countdown, play, miss penalty and game over. Drives the puck datapath with a one-cycle re-centre pulse, a motion enable and the current puck speed, and keeps score and lives. Sits between the button/switch inputs and the pong puck/paddle update logic; all timing is counted in frames via `nf_in`.

## Interface

Parameters:
- `SERVE_FRAMES`, 60: frames the puck is held centred before launch; must be ≥1.
- `MISS_FRAMES`, 30: frames spent in the miss penalty state; must be ≥1.
- `LIVES`, 3: lives per game, 1..7.
- `BASE_SPEED`, 2: puck speed at game start, 4-bit.
- `MAX_SPEED`, 8: speed ceiling, 4-bit, ≥ `BASE_SPEED`.
- `HITS_PER_LEVEL`, 4: paddle hits per speed increment, ≥1.

Ports:
- `pixel_clk_in` input 1: the single clock.
- `rst_n_in` input 1: reset, synchronous, active-low.
- `nf_in` input 1: new-frame strobe, one cycle per frame.
- `start_in` input 1: start button, level; internally rising-edge detected.
- `pause_in` input 1: level; freezes play while high.
- `hit_in` input 1: one-cycle pulse from the datapath when the puck bounces off the paddle.
- `miss_in` input 1: one-cycle pulse from the datapath when the puck passes the paddle.
- `state_out` output 3: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
- `serve_out` output 1: one-cycle pulse telling the datapath to re-centre the puck.
- `run_out` output 1: puck/paddle motion enable.
- `speed_out` output 4: puck speed for the datapath.
- `score_out` output 8: hit count, saturating.
- `lives_out` output 3: remaining lives.
- `game_over_out` output 1: high in OVER.

## Operation

- Start edge: `start_in`=1 while the previous-cycle sample was 0. The sample register resets to 1, so a button held through reset does not start a game.
- IDLE: on a start edge, go to SERVE. Load lives=`LIVES`, score=0, speed=`BASE_SPEED`, hit counter=0, frame counter=`SERVE_FRAMES`.
- SERVE: each `nf_in` decrements the frame counter. The `nf_in` that takes the counter from 1 to 0 moves to PLAY. Hit and miss are ignored. Pause is ignored.
- PLAY, miss has priority:
  - If `miss_in`=1 and lives=1: lives go to 0, next state OVER.
  - If `miss_in`=1 and lives>1: lives decrement, frame counter=`MISS_FRAMES`, next state MISS.
  - Otherwise, if `hit_in`=1: score+1, saturating at 255.
  - Hit counter increments. On reaching `HITS_PER_LEVEL` it wraps to 0 and speed goes +1, saturating at `MAX_SPEED`.
  - `pause_in` does not block event acceptance.
- MISS: each `nf_in` decrements the frame counter. Reaching 0 moves to SERVE with frame counter=`SERVE_FRAMES`. Speed, score and hit counter are kept.
- OVER: score and lives are held. A start edge starts a new game, with the same loads as from IDLE.
- `hit_in`/`miss_in` outside PLAY are ignored.

## Timing

- All outputs are registered.
- Reset values: `state_out`=0, `serve_out`=0, `run_out`=0, `speed_out`=`BASE_SPEED`, `score_out`=0, `lives_out`=`LIVES`, `game_over_out`=0.
- Reset asserted mid-game: the reset values appear on the cycle after the sampling edge. The frame and hit counters clear and the start sample is set to 1.
- State changes appear one cycle after the triggering input is sampled.
- `serve_out` is high exactly on the first cycle `state_out`=SERVE, from both IDLE/OVER and MISS entries. It is low otherwise.
- `run_out` = registered (next state is PLAY && !`pause_in`). It is high from the first PLAY cycle and drops one cycle after `pause_in` rises.
- `score_out`, `lives_out` and `speed_out` update one cycle after the accepted hit/miss pulse, together with the state change.
- `game_over_out` is high on exactly the cycles where `state_out`=OVER.
- Simultaneous `hit_in`+`miss_in` in PLAY: miss only; score and speed are unchanged.
- `nf_in` coincident with a start edge in IDLE: the start is taken, and that `nf_in` does not decrement the freshly loaded counter.
- Back-to-back `nf_in` on consecutive cycles: each one counts.

## Test plan

Parameters for all scenarios: SERVE_FRAMES=2, MISS_FRAMES=1, LIVES=2, BASE_SPEED=2, MAX_SPEED=3, HITS_PER_LEVEL=2.

1. Reset, then a start edge, then two `nf_in` strobes:
   - `serve_out` pulses once on the first SERVE cycle.
   - State goes IDLE→SERVE→PLAY one cycle after the 2nd `nf_in`.
   - `run_out`=1 from that cycle; `lives_out`=2, `speed_out`=2.
2. In PLAY, five `hit_in` pulses:
   - `score_out` reads 1,2,3,4,5.
   - `speed_out` goes to 3 after the 2nd hit and stays 3 (saturated) after the 4th.
3. In PLAY, `miss_in`:
   - MISS is entered with `lives_out`=1 and `run_out`=0.
   - After one `nf_in`, state is SERVE with a `serve_out` pulse.
   - After two more `nf_in`, state is PLAY; score and speed are unchanged.
4. With lives=1, `hit_in` and `miss_in` in the same cycle:
   - State goes to OVER, `lives_out`=0, `game_over_out`=1, score unchanged.
   - `start_in` held high does nothing; a release then press starts a new game with score=0, lives=2, speed=2.
5. In PLAY, raise `pause_in` for 3 cycles:
   - `run_out` falls one cycle after `pause_in` rises and returns one cycle after it falls; state stays PLAY.
   - A `hit_in` while paused still increments score.
6. `start_in` held high across reset release: the game stays in IDLE. Mid-PLAY with score=5, pull `rst_n_in` low for one cycle: all outputs return to their reset values on the next cycle.
